// File: rtl/i2c_eeprom_slave.sv
// i2c_eeprom_slave: oversampled I2C EEPROM responder; `define I2C_SLV_WP_EN adds the wp write-protect input
module i2c_eeprom_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1010000,
  parameter int         MEM_AW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_ctrl,
  input  logic              scl,
  inout  wire               sda,
`ifdef I2C_SLV_WP_EN
  input  logic              wp,
`endif
  output logic              busy,
  output logic              wr_pulse,
  output logic [MEM_AW-1:0] cur_addr
);
  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, WADDR_HI, WADDR_HI_ACK, WADDR_LO, WADDR_LO_ACK,
    WR_DATA, WR_ACK, RD_DATA, RD_MACK, WAIT_STOP
  } state_t;
  state_t            r_state, w_state;
  logic              r_scl_s1, r_scl_s2, r_scl_d, r_sda_s1, r_sda_s2, r_sda_d;
  logic [3:0]        r_cnt, w_cnt;
  logic [7:0]        r_shift, w_shift, r_tx, w_tx, r_hi, w_hi, w_byte, w_rd;
  logic              r_bc, w_bc, r_sda_low, w_sda_low, r_wr_pulse, w_we, w_wp;
  logic [MEM_AW-1:0] r_addr, w_addr;
  logic [15:0]       w_full;
  logic              w_rise, w_fall, w_start, w_stop, w_rx, w_match;
  logic [7:0]        r_mem [0:(1<<MEM_AW)-1];
`ifdef I2C_SLV_WP_EN
  assign w_wp = wp;
`else
  assign w_wp = 1'b0;
`endif
  assign sda      = r_sda_low ? 1'b0 : 1'bz;
  assign busy     = r_state != IDLE;
  assign wr_pulse = r_wr_pulse;
  assign cur_addr = r_addr;
  assign w_rise   = r_scl_s2 & ~r_scl_d;
  assign w_fall   = ~r_scl_s2 & r_scl_d;
  assign w_start  = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop   = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_rx     = r_state == DEV_ADDR || r_state == WADDR_HI || r_state == WADDR_LO || r_state == WR_DATA;
  assign w_match  = r_shift[7:1] == SLAVE_ADDR;
  assign w_byte   = {r_shift[6:0], r_sda_s2};
  assign w_full   = {r_hi, r_shift};
  assign w_rd     = r_mem[r_addr];
  always_ff @(posedge clk)
    if (rst) {r_scl_s1, r_scl_s2, r_scl_d, r_sda_s1, r_sda_s2, r_sda_d} <= '1;
    else {r_scl_s1, r_scl_s2, r_scl_d, r_sda_s1, r_sda_s2, r_sda_d} <= {scl, r_scl_s1, r_scl_s2, sda, r_sda_s1, r_sda_s2};
  always_ff @(posedge clk)
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_tx       <= '0;
      r_hi       <= '0;
      r_bc       <= 1'b0;
      r_sda_low  <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_addr     <= '0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_shift    <= w_shift;
      r_tx       <= w_tx;
      r_hi       <= w_hi;
      r_bc       <= w_bc;
      r_sda_low  <= w_sda_low;
      r_wr_pulse <= w_we;
      r_addr     <= w_addr;
    end
  always_ff @(posedge clk)
    if (w_we) r_mem[r_addr] <= w_byte;
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_shift   = r_shift;
    w_tx      = r_tx;
    w_hi      = r_hi;
    w_bc      = r_bc;
    w_addr    = r_addr;
    w_sda_low = r_sda_low;
    w_we      = 1'b0;
    if (w_start) begin
      w_state   = DEV_ADDR;
      w_cnt     = '0;
      w_sda_low = 1'b0;
      w_hi      = '0;
      w_bc      = bit_ctrl;
    end else if (w_stop) begin
      w_state   = IDLE;
      w_sda_low = 1'b0;
    end else if (w_rise && w_rx && r_cnt != 4'd8) begin
      w_shift = w_byte;
      w_cnt   = r_cnt + 4'd1;
      if (r_state == WR_DATA && r_cnt == 4'd7) begin
        w_we   = !w_wp;
        w_addr = r_addr + 1'b1;
      end
    end else if (w_rise && r_state == RD_MACK && r_cnt == 4'd0) begin
      w_addr  = r_addr + 1'b1;
      w_state = r_sda_s2 ? WAIT_STOP : RD_MACK;
      w_cnt   = 4'd1;
    end else if (w_fall) begin
      case (r_state)
        DEV_ADDR: if (r_cnt == 4'd8) begin
          w_cnt     = '0;
          w_sda_low = w_match;
          w_state   = w_match ? DEV_ACK : WAIT_STOP;
        end
        WADDR_HI: if (r_cnt == 4'd8) begin
          w_cnt     = '0;
          w_sda_low = 1'b1;
          w_hi      = r_shift;
          w_state   = WADDR_HI_ACK;
        end
        WADDR_LO: if (r_cnt == 4'd8) begin
          w_cnt     = '0;
          w_sda_low = 1'b1;
          w_addr    = w_full[MEM_AW-1:0];
          w_state   = WADDR_LO_ACK;
        end
        WR_DATA: if (r_cnt == 4'd8) begin
          w_cnt     = '0;
          w_sda_low = !w_wp;
          w_state   = WR_ACK;
        end
        DEV_ACK: begin
          w_cnt     = '0;
          w_tx      = w_rd;
          w_sda_low = r_shift[0] & ~w_rd[7];
          w_state   = r_shift[0] ? RD_DATA : r_bc ? WADDR_HI : WADDR_LO;
        end
        WADDR_HI_ACK: begin
          w_cnt     = '0;
          w_sda_low = 1'b0;
          w_state   = WADDR_LO;
        end
        WADDR_LO_ACK, WR_ACK: begin
          w_cnt     = '0;
          w_sda_low = 1'b0;
          w_state   = WR_DATA;
        end
        RD_DATA: begin
          w_cnt     = r_cnt == 4'd7 ? 4'd0 : r_cnt + 4'd1;
          w_tx      = {r_tx[6:0], 1'b0};
          w_sda_low = r_cnt != 4'd7 && !r_tx[6];
          w_state   = r_cnt == 4'd7 ? RD_MACK : RD_DATA;
        end
        RD_MACK: if (r_cnt == 4'd1) begin
          w_cnt     = '0;
          w_tx      = w_rd;
          w_sda_low = ~w_rd[7];
          w_state   = RD_DATA;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// tb_i2c_eeprom_slave: directed I2C master transactions against the EEPROM responder
module tb_i2c_eeprom_slave;
  localparam int Q = 200;
  logic       clk = 1'b0, rst = 1'b1, bit_ctrl = 1'b0, scl = 1'b1, m_low = 1'b0;
  logic       busy, wr_pulse;
  logic [7:0] cur_addr;
  wire        sda;
  int         n_chk = 0, n_pass = 0, wr_cnt = 0, drv_cnt = 0;
`ifdef I2C_SLV_WP_EN
  logic       wp = 1'b0;
`endif
  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (wr_pulse) wr_cnt <= wr_cnt + 1;
    if (sda === 1'b0 && !m_low) drv_cnt <= drv_cnt + 1;
  end
  i2c_eeprom_slave dut (
    .clk(clk), .rst(rst), .bit_ctrl(bit_ctrl), .scl(scl), .sda(sda),
`ifdef I2C_SLV_WP_EN
    .wp(wp),
`endif
    .busy(busy), .wr_pulse(wr_pulse), .cur_addr(cur_addr)
  );

  task automatic i2c_start;
    m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask
  task automatic i2c_stop;
    m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #Q;
  endtask
  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_low = ~b[i]; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    end
    m_low = 1'b0; #Q; scl = 1'b1; #Q; ack = sda; #Q; scl = 1'b0; #Q;
  endtask
  task automatic read_byte(input logic nack, output logic [7:0] b);
    m_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      #Q; scl = 1'b1; #Q; b[i] = sda; #Q; scl = 1'b0;
    end
    #Q; m_low = ~nack; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q; m_low = 1'b0;
  endtask

  task automatic test_reset;
    repeat (5) @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (wr_pulse !== 1'b0) $display("FAIL reset_wr_pulse: got %b want 0", wr_pulse); else n_pass++;
    n_chk++; if (cur_addr !== 8'h00) $display("FAIL reset_cur_addr: got %h want 00", cur_addr); else n_pass++;
    n_chk++; if (sda !== 1'b1) $display("FAIL reset_sda: got %b want 1", sda); else n_pass++;
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_byte_write;
    logic a0, a1, a2; int w0;
    w0 = wr_cnt;
    i2c_start;
    n_chk++; if (busy !== 1'b1) $display("FAIL bw_busy_start: got %b want 1", busy); else n_pass++;
    write_byte(8'hA0, a0); write_byte(8'h12, a1); write_byte(8'h5A, a2);
    i2c_stop; #Q;
    n_chk++; if ({a0, a1, a2} !== 3'b000) $display("FAIL bw_acks: got %b want 000", {a0, a1, a2}); else n_pass++;
    n_chk++; if (wr_cnt - w0 !== 1) $display("FAIL bw_wr_pulses: got %0d want 1", wr_cnt - w0); else n_pass++;
    n_chk++; if (cur_addr !== 8'h13) $display("FAIL bw_cur_addr: got %h want 13", cur_addr); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL bw_busy_stop: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_random_read;
    logic a0, a1, a2; logic [7:0] d; int w0;
    w0 = wr_cnt;
    i2c_start; write_byte(8'hA0, a0); write_byte(8'h12, a1);
    i2c_start; write_byte(8'hA1, a2); read_byte(1'b1, d);
    n_chk++; if ({a0, a1, a2} !== 3'b000) $display("FAIL rr_acks: got %b want 000", {a0, a1, a2}); else n_pass++;
    n_chk++; if (d !== 8'h5A) $display("FAIL rr_data: got %h want 5a", d); else n_pass++;
    n_chk++; if (wr_cnt - w0 !== 0) $display("FAIL rr_no_write: got %0d want 0", wr_cnt - w0); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL rr_wait_stop_busy: got %b want 1", busy); else n_pass++;
    n_chk++; if (cur_addr !== 8'h13) $display("FAIL rr_cur_addr: got %h want 13", cur_addr); else n_pass++;
    i2c_stop; #Q;
    n_chk++; if (busy !== 1'b0) $display("FAIL rr_busy_idle: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_wrap;
    logic a0, a1, a2, a3, a4; logic [7:0] d0, d1, d2; int w0;
    w0 = wr_cnt;
    i2c_start; write_byte(8'hA0, a0); write_byte(8'hFE, a1);
    write_byte(8'h11, a2); write_byte(8'h22, a3); write_byte(8'h33, a4);
    i2c_stop; #Q;
    n_chk++; if ({a0, a1, a2, a3, a4} !== 5'b0) $display("FAIL wrap_wr_acks: got %b want 00000", {a0, a1, a2, a3, a4}); else n_pass++;
    n_chk++; if (wr_cnt - w0 !== 3) $display("FAIL wrap_wr_pulses: got %0d want 3", wr_cnt - w0); else n_pass++;
    n_chk++; if (cur_addr !== 8'h01) $display("FAIL wrap_wr_cur_addr: got %h want 01", cur_addr); else n_pass++;
    i2c_start; write_byte(8'hA0, a0); write_byte(8'hFE, a1);
    i2c_start; write_byte(8'hA1, a2);
    read_byte(1'b0, d0); read_byte(1'b0, d1); read_byte(1'b1, d2);
    i2c_stop; #Q;
    n_chk++; if ({d0, d1, d2} !== 24'h112233) $display("FAIL wrap_rd_data: got %h want 112233", {d0, d1, d2}); else n_pass++;
    n_chk++; if (cur_addr !== 8'h01) $display("FAIL wrap_rd_cur_addr: got %h want 01", cur_addr); else n_pass++;
  endtask

  task automatic test_mismatch;
    logic a0, a1, a2; logic [7:0] d; int w0, v0;
    w0 = wr_cnt; v0 = drv_cnt;
    i2c_start; write_byte(8'hA2, a0); write_byte(8'h12, a1); write_byte(8'h77, a2);
    i2c_stop; #Q;
    n_chk++; if ({a0, a1, a2} !== 3'b111) $display("FAIL mm_nacks: got %b want 111", {a0, a1, a2}); else n_pass++;
    n_chk++; if (drv_cnt - v0 !== 0) $display("FAIL mm_sda_driven: got %0d want 0", drv_cnt - v0); else n_pass++;
    n_chk++; if (wr_cnt - w0 !== 0) $display("FAIL mm_no_write: got %0d want 0", wr_cnt - w0); else n_pass++;
    i2c_start; write_byte(8'hA0, a0); write_byte(8'h12, a1);
    i2c_start; write_byte(8'hA1, a2); read_byte(1'b1, d);
    i2c_stop; #Q;
    n_chk++; if (d !== 8'h5A) $display("FAIL mm_mem_kept: got %h want 5a", d); else n_pass++;
  endtask

  task automatic test_bit_ctrl;
    logic a0, a1, a2, a3; logic [7:0] d; int w0;
    w0 = wr_cnt;
    bit_ctrl = 1'b1;
    i2c_start; write_byte(8'hA0, a0); write_byte(8'h01, a1); write_byte(8'h34, a2); write_byte(8'hC3, a3);
    i2c_stop; #Q;
    n_chk++; if ({a0, a1, a2, a3} !== 4'b0) $display("FAIL bc_acks: got %b want 0000", {a0, a1, a2, a3}); else n_pass++;
    n_chk++; if (wr_cnt - w0 !== 1) $display("FAIL bc_wr_pulses: got %0d want 1", wr_cnt - w0); else n_pass++;
    n_chk++; if (cur_addr !== 8'h35) $display("FAIL bc_cur_addr: got %h want 35", cur_addr); else n_pass++;
    i2c_start; write_byte(8'hA0, a0); write_byte(8'h00, a1); write_byte(8'h34, a2);
    i2c_start; write_byte(8'hA1, a3); read_byte(1'b1, d);
    i2c_stop; #Q;
    bit_ctrl = 1'b0;
    n_chk++; if (d !== 8'hC3) $display("FAIL bc_readback: got %h want c3", d); else n_pass++;
  endtask

`ifdef I2C_SLV_WP_EN
  task automatic test_write_protect;
    logic a0, a1, a2; logic [7:0] d; int w0;
    w0 = wr_cnt;
    wp = 1'b1;
    i2c_start; write_byte(8'hA0, a0); write_byte(8'h12, a1); write_byte(8'h99, a2);
    i2c_stop; #Q;
    wp = 1'b0;
    n_chk++; if ({a0, a1, a2} !== 3'b001) $display("FAIL wp_acks: got %b want 001", {a0, a1, a2}); else n_pass++;
    n_chk++; if (wr_cnt - w0 !== 0) $display("FAIL wp_no_write: got %0d want 0", wr_cnt - w0); else n_pass++;
    n_chk++; if (cur_addr !== 8'h13) $display("FAIL wp_cur_addr: got %h want 13", cur_addr); else n_pass++;
    i2c_start; write_byte(8'hA0, a0); write_byte(8'h12, a1);
    i2c_start; write_byte(8'hA1, a2); read_byte(1'b1, d);
    i2c_stop; #Q;
    n_chk++; if (d !== 8'h5A) $display("FAIL wp_mem_kept: got %h want 5a", d); else n_pass++;
  endtask
`endif

  task automatic test_reset_mid_read;
    logic a0, a1, a2;
    i2c_start; write_byte(8'hA0, a0); write_byte(8'h12, a1);
    i2c_start; write_byte(8'hA1, a2);
    n_chk++; if (sda !== 1'b0) $display("FAIL rm_driving_zero: got %b want 0", sda); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (sda !== 1'b1) $display("FAIL rm_sda_released: got %b want 1", sda); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (cur_addr !== 8'h00) $display("FAIL rm_cur_addr: got %h want 00", cur_addr); else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    i2c_stop; #Q;
    n_chk++; if (busy !== 1'b0) $display("FAIL rm_busy_after: got %b want 0", busy); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_byte_write;
    test_random_read;
    test_wrap;
    test_mismatch;
    test_bit_ctrl;
`ifdef I2C_SLV_WP_EN
    test_write_protect;
`endif
    test_reset_mid_read;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
